// File: rtl/system_bridge.sv
// system_bridge: CPU data-port bridge to data memory (DM), two programmable
// timers (TC0/TC1) and an external-interrupt acknowledge register.
// Optional build macro: SYSTEM_BRIDGE_TC1_EN builds TC1; when it is left
// undefined, the TC1 window is unmapped and hw_int[1] is tied to 0.

// One timer: CTRL {IM, MODE[1:0], EN}, PRESET and a read-only COUNT.
module system_bridge_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_ctrl,
    input  logic        we_preset,
    input  logic [31:0] wdata,
    output logic [3:0]  ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;
    logic        auto_mode;

    // Only MODE 01 reloads; 00, 10 and 11 all behave as one-shot.
    assign auto_mode = (ctrl_q[2:1] == 2'b01);

    // Next-state: FSM step first, then CPU writes override CTRL/PRESET.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: if (ctrl_q[0]) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0])          state_d = ST_IDLE;
                else if (count_q == '0)  state_d = ST_INT;
                else                     count_d = count_q - 32'd1;
            end
            ST_INT: begin
                if (auto_mode) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Auto-reload pending is a single-cycle strobe.
        if (auto_mode && state_q != ST_INT) pending_d = 1'b0;
        if (we_preset) preset_d = wdata;
        if (we_ctrl) begin
            ctrl_d    = wdata[3:0];
            pending_d = 1'b0;
            if (!wdata[0]) state_d = ST_IDLE;
        end
        // An expiring count is never lost to a concurrent CTRL write.
        if (state_q == ST_INT) pending_d = 1'b1;
        irq_d = ctrl_d[3] & pending_d;
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign ctrl   = ctrl_q;
    assign preset = preset_q;
    assign count  = count_q;
    assign irq    = irq_q;
endmodule

module system_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic        m_data_mem_write,
    input  logic [2:0]  m_data_sel,
    input  logic        m_data_req,
    output logic [31:0] m_data_rdata,
    output logic [4:0]  m_data_exc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    input  logic        ext_int,
    output logic [5:0]  hw_int
);
    logic        is_word, is_half, is_byte, is_sext, valid;
    logic        in_dm, in_tc0, in_tc1, in_ack, in_reg, fault, store_ok;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] preset0, preset1, count0, count1;
    logic        irq0, irq1;
    logic [31:0] rd_tc0, rd_tc1, rd_reg;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic        int_pending_q, int_pending_d;

    assign is_word = (m_data_sel == 3'b001);
    assign is_half = (m_data_sel == 3'b010) || (m_data_sel == 3'b011);
    assign is_byte = (m_data_sel == 3'b100) || (m_data_sel == 3'b101);
    assign is_sext = (m_data_sel == 3'b010) || (m_data_sel == 3'b100);
    assign valid   = is_word | is_half | is_byte;

    assign in_dm  = (m_data_addr < 32'h0000_3000);
    assign in_tc0 = (m_data_addr[31:4] == 28'h00007F0) && (m_data_addr[3:2] != 2'b11);
    assign in_ack = (m_data_addr[31:2] == 30'h00001FC8);
    assign in_reg = in_tc0 | in_tc1 | in_ack;

    // Fault classification and the single store-accept qualifier.
    always_comb begin
        fault = 1'b0;
        if (valid) begin
            if (!(in_dm | in_reg))                        fault = 1'b1;
            if (is_word && m_data_addr[1:0] != 2'b00)     fault = 1'b1;
            if (is_half && m_data_addr[0])                fault = 1'b1;
            if (!is_word && in_reg)                       fault = 1'b1;
            if (m_data_mem_write && (in_tc0 | in_tc1) && m_data_addr[3:2] == 2'b10)
                                                          fault = 1'b1;
        end
        m_data_exc = fault ? (m_data_mem_write ? 5'd5 : 5'd4) : 5'd0;
        store_ok   = valid & ~fault & m_data_mem_write & ~m_data_req;
    end

    // DM write path: word address, replicated data, lane enables.
    always_comb begin
        dm_addr   = {m_data_addr[31:2], 2'b00};
        dm_wdata  = m_data_wdata;
        dm_byteen = 4'b0000;
        if (is_half) dm_wdata = {2{m_data_wdata[15:0]}};
        if (is_byte) dm_wdata = {4{m_data_wdata[7:0]}};
        if (store_ok && in_dm) begin
            if (is_word)      dm_byteen = 4'b1111;
            else if (is_half) dm_byteen = m_data_addr[1] ? 4'b1100 : 4'b0011;
            else              dm_byteen = 4'b0001 << m_data_addr[1:0];
        end
    end

    // Read path: lane select and extension for DM, full words for registers.
    always_comb begin
        half_lane = m_data_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (m_data_addr[1:0])
            2'd0:    byte_lane = dm_rdata[7:0];
            2'd1:    byte_lane = dm_rdata[15:8];
            2'd2:    byte_lane = dm_rdata[23:16];
            default: byte_lane = dm_rdata[31:24];
        endcase
        case (m_data_addr[3:2])
            2'd0:    rd_tc0 = {28'd0, ctrl0};
            2'd1:    rd_tc0 = preset0;
            default: rd_tc0 = count0;
        endcase
        rd_reg = in_tc0 ? rd_tc0 : in_tc1 ? rd_tc1 : {31'd0, int_pending_q};
        m_data_rdata = '0;
        if (valid && !fault) begin
            if (!in_dm)       m_data_rdata = rd_reg;
            else if (is_word) m_data_rdata = dm_rdata;
            else if (is_half) m_data_rdata = {{16{is_sext & half_lane[15]}}, half_lane};
            else              m_data_rdata = {{24{is_sext & byte_lane[7]}}, byte_lane};
        end
    end

    system_bridge_timer u_tc0 (
        .clk       (clk),
        .reset     (reset),
        .we_ctrl   (store_ok & in_tc0 & (m_data_addr[3:2] == 2'b00)),
        .we_preset (store_ok & in_tc0 & (m_data_addr[3:2] == 2'b01)),
        .wdata     (m_data_wdata),
        .ctrl      (ctrl0),
        .preset    (preset0),
        .count     (count0),
        .irq       (irq0)
    );

`ifdef SYSTEM_BRIDGE_TC1_EN
    assign in_tc1 = (m_data_addr[31:4] == 28'h00007F1) && (m_data_addr[3:2] != 2'b11);

    system_bridge_timer u_tc1 (
        .clk       (clk),
        .reset     (reset),
        .we_ctrl   (store_ok & in_tc1 & (m_data_addr[3:2] == 2'b00)),
        .we_preset (store_ok & in_tc1 & (m_data_addr[3:2] == 2'b01)),
        .wdata     (m_data_wdata),
        .ctrl      (ctrl1),
        .preset    (preset1),
        .count     (count1),
        .irq       (irq1)
    );

    // TC1 register read select.
    always_comb begin
        case (m_data_addr[3:2])
            2'd0:    rd_tc1 = {28'd0, ctrl1};
            2'd1:    rd_tc1 = preset1;
            default: rd_tc1 = count1;
        endcase
    end
`else
    assign in_tc1  = 1'b0;
    assign ctrl1   = 4'd0;
    assign preset1 = 32'd0;
    assign count1  = 32'd0;
    assign irq1    = 1'b0;
    assign rd_tc1  = 32'd0;
`endif

    // External interrupt latch; an acknowledge store beats a new request.
    always_comb begin
        int_pending_d = int_pending_q | ext_int;
        if (store_ok && in_ack) int_pending_d = 1'b0;
    end

    // External interrupt pending register.
    always_ff @(posedge clk) begin
        if (reset) int_pending_q <= 1'b0;
        else       int_pending_q <= int_pending_d;
    end

    assign hw_int = {3'b000, int_pending_q, irq1, irq0};
endmodule

// File: tb/tb_system_bridge.sv
// Self-checking bench for system_bridge: vector table for decode/lane
// behaviour, hand sequences for timers, interrupt ack and reset.
module tb_system_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr, m_data_wdata;
    logic        m_data_mem_write, m_data_req, ext_int;
    logic [2:0]  m_data_sel;
    logic [31:0] m_data_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [4:0]  m_data_exc;
    logic [3:0]  dm_byteen;
    logic [5:0]  hw_int;

    int total = 0;
    int bad   = 0;

    system_bridge dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_mem_write(m_data_mem_write), .m_data_sel(m_data_sel),
        .m_data_req(m_data_req), .m_data_rdata(m_data_rdata),
        .m_data_exc(m_data_exc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
        .ext_int(ext_int), .hw_int(hw_int)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, byte-enabled write.
    logic [31:0] mem [0:3071];
    assign dm_rdata = (dm_addr < 32'h3000) ? mem[dm_addr[13:2]] : 32'd0;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dm_byteen[i] && dm_addr < 32'h3000)
                mem[dm_addr[13:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
    end

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic [4:0]  exc;
        logic [3:0]  be;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        req;
        exp_t        e;
    } vec_t;

    exp_t sbq [$];

    localparam logic [2:0] NONE = 3'b000, W = 3'b001, H = 3'b010, HU = 3'b011,
                           B = 3'b100, BU = 3'b101;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive after the edge, expectation queued, compared mid-cycle.
    task automatic access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic req, input exp_t e,
                          input string nm);
        exp_t got;
        @(posedge clk); #1;
        m_data_mem_write = we; m_data_sel = sel; m_data_addr = addr;
        m_data_wdata = wdata; m_data_req = req;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            got = sbq.pop_front();
            if (got.chk_rd) chk({nm, ".rdata"}, m_data_rdata, got.rd);
            chk({nm, ".exc"}, {27'd0, m_data_exc}, {27'd0, got.exc});
            chk({nm, ".byteen"}, {28'd0, dm_byteen}, {28'd0, got.be});
        end
    endtask

    function automatic exp_t ex(input logic c, input logic [31:0] rd, input logic [4:0] exc,
                                input logic [3:0] be);
        ex = '{chk_rd: c, rd: rd, exc: exc, be: be};
    endfunction

    task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        access(1'b0, W, addr, 32'd0, 1'b0, ex(1'b1, exp, 5'd0, 4'd0), nm);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] d, input string nm);
        access(1'b1, W, addr, d, 1'b0, ex(1'b0, 32'd0, 5'd0, 4'd0), nm);
    endtask

    vec_t vt [0:21];
    logic [4:0] tc1_exc;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3072; i++) mem[i] = 32'd0;
`ifdef SYSTEM_BRIDGE_TC1_EN
        tc1_exc = 5'd0;
`else
        tc1_exc = 5'd4;
`endif
        //            we   sel   addr           wdata          req  expected
        vt[0]  = '{1'b1, W,  32'h100,  32'h12345678, 1'b0, ex(0, 0, 0, 4'b1111)};
        vt[1]  = '{1'b0, B,  32'h103,  32'h0,        1'b0, ex(1, 32'h12, 0, 0)};
        vt[2]  = '{1'b0, H,  32'h102,  32'h0,        1'b0, ex(1, 32'h1234, 0, 0)};
        vt[3]  = '{1'b0, HU, 32'h100,  32'h0,        1'b0, ex(1, 32'h5678, 0, 0)};
        vt[4]  = '{1'b1, B,  32'h5,    32'h80,       1'b0, ex(0, 0, 0, 4'b0010)};
        vt[5]  = '{1'b0, B,  32'h5,    32'h0,        1'b0, ex(1, 32'hFFFFFF80, 0, 0)};
        vt[6]  = '{1'b0, BU, 32'h5,    32'h0,        1'b0, ex(1, 32'h80, 0, 0)};
        vt[7]  = '{1'b0, W,  32'h102,  32'h0,        1'b0, ex(1, 0, 5'd4, 0)};
        vt[8]  = '{1'b1, H,  32'h7F00, 32'h1,        1'b0, ex(0, 0, 5'd5, 0)};
        vt[9]  = '{1'b1, W,  32'h7F08, 32'h5,        1'b0, ex(0, 0, 5'd5, 0)};
        vt[10] = '{1'b1, W,  32'h3000, 32'h5,        1'b0, ex(0, 0, 5'd5, 0)};
        vt[11] = '{1'b1, W,  32'h0,    32'hDEADBEEF, 1'b1, ex(0, 0, 0, 0)};
        vt[12] = '{1'b0, W,  32'h0,    32'h0,        1'b0, ex(1, 0, 0, 0)};
        vt[13] = '{1'b0, W,  32'h7F10, 32'h0,        1'b0, ex(0, 0, tc1_exc, 0)};
        vt[14] = '{1'b0, NONE, 32'h3001, 32'h0,      1'b0, ex(1, 0, 0, 0)};
        vt[15] = '{1'b1, 3'b110, 32'h7, 32'hFF,      1'b0, ex(0, 0, 0, 0)};
        vt[16] = '{1'b1, H,  32'h202,  32'h8001,     1'b0, ex(0, 0, 0, 4'b1100)};
        vt[17] = '{1'b0, H,  32'h202,  32'h0,        1'b0, ex(1, 32'hFFFF8001, 0, 0)};
        vt[18] = '{1'b0, HU, 32'h202,  32'h0,        1'b0, ex(1, 32'h8001, 0, 0)};
        vt[19] = '{1'b0, H,  32'h101,  32'h0,        1'b0, ex(1, 0, 5'd4, 0)};
        vt[20] = '{1'b1, B,  32'h7F20, 32'h0,        1'b0, ex(0, 0, 5'd5, 0)};
        vt[21] = '{1'b1, W,  32'h7F0C, 32'h0,        1'b0, ex(0, 0, 5'd5, 0)};

        reset = 1'b1; ext_int = 1'b0;
        m_data_mem_write = 1'b0; m_data_sel = NONE; m_data_addr = '0;
        m_data_wdata = '0; m_data_req = 1'b0;
        // Combinational decode is live during reset.
        access(1'b0, W, 32'h102, 32'd0, 1'b0, ex(1, 0, 5'd4, 0), "rst_exc");
        access(1'b0, NONE, 32'd0, 32'd0, 1'b0, ex(1, 0, 0, 0), "rst_idle");
        chk("rst_hw_int", {26'd0, hw_int}, 32'd0);
        reset = 1'b0;
        rd_reg(32'h7F00, 32'd0, "rst_ctrl0");
        rd_reg(32'h7F04, 32'd0, "rst_preset0");
        rd_reg(32'h7F08, 32'd0, "rst_count0");
        rd_reg(32'h7F20, 32'd0, "rst_ack");

        for (int i = 0; i <= 21; i++)
            access(vt[i].we, vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].req, vt[i].e,
                   $sformatf("vec%0d", i));

        // One-shot with IM: COUNT 3,2,1,0 on cycles 2..5, irq held from cycle 7.
        wr_reg(32'h7F04, 32'd3, "os_preset");
        wr_reg(32'h7F00, 32'h9, "os_ctrl");
        for (int k = 0; k < 10; k++) begin
            rd_reg(32'h7F08, (k >= 2 && k <= 5) ? 32'(5 - k) : 32'd0,
                   $sformatf("os_count%0d", k));
            chk($sformatf("os_irq%0d", k), {31'd0, hw_int[0]}, {31'd0, k >= 7});
        end
        rd_reg(32'h7F00, 32'h8, "os_ctrl_en_clr");
        chk("os_irq_held", {31'd0, hw_int[0]}, 32'd1);
        wr_reg(32'h7F00, 32'h0, "os_ctrl_rewrite");
        rd_reg(32'h7F04, 32'd3, "os_preset_rd");
        chk("os_irq_cleared", {31'd0, hw_int[0]}, 32'd0);

        // Auto-reload: one-cycle pulse every 5 cycles, then stop mid-count.
        wr_reg(32'h7F04, 32'd2, "ar_preset");
        wr_reg(32'h7F00, 32'hB, "ar_ctrl");
        for (int k = 0; k < 18; k++) begin
            rd_reg(32'h7F00, 32'hB, $sformatf("ar_ctrl%0d", k));
            chk($sformatf("ar_irq%0d", k), {31'd0, hw_int[0]},
                {31'd0, (k >= 6) && ((k - 6) % 5 == 0)});
        end
        wr_reg(32'h7F00, 32'h0, "ar_stop");
        for (int k = 0; k < 10; k++) begin
            rd_reg(32'h7F00, 32'h0, $sformatf("ar_stop_ctrl%0d", k));
            chk($sformatf("ar_stop_irq%0d", k), {31'd0, hw_int[0]}, 32'd0);
        end

        // MODE 10 behaves as one-shot: irq from cycle 5, EN cleared.
        wr_reg(32'h7F04, 32'd1, "m2_preset");
        wr_reg(32'h7F00, 32'hD, "m2_ctrl");
        for (int k = 0; k < 9; k++) begin
            rd_reg(32'h7F04, 32'd1, $sformatf("m2_preset%0d", k));
            chk($sformatf("m2_irq%0d", k), {31'd0, hw_int[0]}, {31'd0, k >= 5});
        end
        rd_reg(32'h7F00, 32'hC, "m2_ctrl_en_clr");
        wr_reg(32'h7F00, 32'h0, "m2_clear");

        // External interrupt latch and acknowledge.
        @(posedge clk); #1 ext_int = 1'b1;
        @(posedge clk); #1 ext_int = 1'b0;
        @(negedge clk);
        chk("ext_set", {31'd0, hw_int[2]}, 32'd1);
        rd_reg(32'h7F20, 32'd1, "ack_rd_pending");
        wr_reg(32'h7F20, 32'd0, "ack_store");
        chk("ext_before_clr", {31'd0, hw_int[2]}, 32'd1);
        rd_reg(32'h7F20, 32'd0, "ack_rd_clear");
        chk("ext_cleared", {31'd0, hw_int[2]}, 32'd0);
        ext_int = 1'b1;
        wr_reg(32'h7F20, 32'd0, "ack_vs_ext");
        ext_int = 1'b0;
        rd_reg(32'h7F20, 32'd0, "ack_wins_rd");
        chk("ack_wins", {31'd0, hw_int[2]}, 32'd0);

        // Reset in the middle of a count abandons it silently.
        wr_reg(32'h7F04, 32'd5, "rm_preset");
        wr_reg(32'h7F00, 32'h9, "rm_ctrl");
        rd_reg(32'h7F00, 32'h9, "rm_ctrl_rd");
        rd_reg(32'h7F00, 32'h9, "rm_ctrl_rd2");
        rd_reg(32'h7F08, 32'd5, "rm_count_mid");
        reset = 1'b1;
        access(1'b0, W, 32'h102, 32'd0, 1'b0, ex(1, 0, 5'd4, 0), "rm_exc_in_rst");
        access(1'b1, W, 32'h0, 32'd0, 1'b0, ex(0, 0, 0, 4'b1111), "rm_be_in_rst");
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd_reg(32'h7F08, 32'd0, $sformatf("rm_count%0d", k));
            chk($sformatf("rm_hw%0d", k), {26'd0, hw_int}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
